out_act_ctrl: RTL and testbench

Sequencer and port arbiter for the single-port output activation buffer. Owns the buffer's only port and shares it between three users: writeback from the add stage (fixed top priority, never stalled), a clear engine that zeroes the buffer before a layer, and a drain engine that reads every entry out to the host over a valid/ready channel. Sits between the add stage's writeback outputs and the output activation SRAM.

---
 rtl/out_act_if.sv | 33 +++
 rtl/out_act_ctrl.sv | 142 ++++++++++++++
 tb/tb_out_act_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/out_act_if.sv
// Bundle of the writeback, buffer-port and host drain channels of the output
// activation sequencer; master is the controller side, slave the environment.
interface out_act_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);
  logic              wb_write_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              mem_wr_en;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              drain_valid;
  logic              drain_ready;
  logic [ADDR_W-1:0] drain_addr;
  logic [DATA_W-1:0] drain_data;

  modport master (
    input  wb_write_en, wb_addr, wb_data, mem_rdata, drain_ready,
    output mem_wr_en, mem_rd_en, mem_addr, mem_wdata,
           drain_valid, drain_addr, drain_data
  );

  modport slave (
    output wb_write_en, wb_addr, wb_data, mem_rdata, drain_ready,
    input  mem_wr_en, mem_rd_en, mem_addr, mem_wdata,
           drain_valid, drain_addr, drain_data
  );
endinterface

// File: rtl/out_act_ctrl.sv
// Port arbiter and clear/drain sequencer for the single-port output activation
// buffer. Define ACT_RELU_EN to clamp negative drain words to zero.
module out_act_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clear_start,
  input  logic      drain_start,
  output logic      busy,
  output logic      done,
  out_act_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_DRAIN_RD,
    S_DRAIN_RESP,
    S_DRAIN_OUT
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [ADDR_W-1:0] drn_addr_q, drn_addr_d;
  logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
  logic [DATA_W-1:0] drain_data_q, drain_data_d;
  logic              drain_valid_q, drain_valid_d;
  logic              busy_q, done_q, done_d;
  logic [DATA_W-1:0] resp_word;

  always_comb begin
`ifdef ACT_RELU_EN
    resp_word = bus.mem_rdata[DATA_W-1] ? '0 : bus.mem_rdata;
`else
    resp_word = bus.mem_rdata;
`endif
  end

  always_comb begin
    state_d       = state_q;
    clr_addr_d    = clr_addr_q;
    drn_addr_d    = drn_addr_q;
    drain_addr_d  = drain_addr_q;
    drain_data_d  = drain_data_q;
    drain_valid_d = drain_valid_q;
    done_d        = 1'b0;
    bus.mem_wr_en = 1'b0;
    bus.mem_rd_en = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;

    // Writeback owns the port unconditionally; engines only use idle cycles.
    if (bus.wb_write_en) begin
      bus.mem_wr_en = 1'b1;
      bus.mem_addr  = bus.wb_addr;
      bus.mem_wdata = bus.wb_data;
    end

    case (state_q)
      S_IDLE: begin
        if (clear_start) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
        end else if (drain_start) begin
          state_d    = S_DRAIN_RD;
          drn_addr_d = '0;
        end
      end
      S_CLEAR: begin
        if (!bus.wb_write_en) begin
          bus.mem_wr_en = 1'b1;
          bus.mem_addr  = clr_addr_q;
          bus.mem_wdata = '0;
          clr_addr_d    = clr_addr_q + 1'b1;
          if (clr_addr_q == LAST_ADDR) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_DRAIN_RD: begin
        if (!bus.wb_write_en) begin
          bus.mem_rd_en = 1'b1;
          bus.mem_addr  = drn_addr_q;
          state_d       = S_DRAIN_RESP;
        end
      end
      S_DRAIN_RESP: begin
        drain_data_d  = resp_word;
        drain_addr_d  = drn_addr_q;
        drain_valid_d = 1'b1;
        state_d       = S_DRAIN_OUT;
      end
      S_DRAIN_OUT: begin
        if (bus.drain_ready) begin
          drain_valid_d = 1'b0;
          drn_addr_d    = drn_addr_q + 1'b1;
          if (drn_addr_q == LAST_ADDR) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_DRAIN_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      clr_addr_q    <= '0;
      drn_addr_q    <= '0;
      drain_addr_q  <= '0;
      drain_data_q  <= '0;
      drain_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_addr_q    <= clr_addr_d;
      drn_addr_q    <= drn_addr_d;
      drain_addr_q  <= drain_addr_d;
      drain_data_q  <= drain_data_d;
      drain_valid_q <= drain_valid_d;
      busy_q        <= (state_d != S_IDLE);
      done_q        <= done_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign bus.drain_valid = drain_valid_q;
  assign bus.drain_addr  = drain_addr_q;
  assign bus.drain_data  = drain_data_q;

endmodule

// File: tb/tb_out_act_ctrl.sv
// Directed bench for out_act_ctrl with a registered-read buffer model.
module tb_out_act_ctrl;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear_start = 1'b0;
  logic drain_start = 1'b0;
  logic busy, done;
  int checks = 0;
  int failures = 0;

  logic [15:0] mem [DEPTH];
  logic [15:0] exp_data [DEPTH];

  out_act_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  out_act_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_start (clear_start),
    .drain_start (drain_start),
    .busy        (busy),
    .done        (done),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wb_write(input logic [5:0] a, input logic [15:0] d);
    bus.wb_write_en = 1'b1;
    bus.wb_addr     = a;
    bus.wb_data     = d;
    #1;
    chk("wb_pass", 32'({bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, bus.mem_wdata}),
        32'({1'b1, 1'b0, a, d}));
    tick();
    bus.wb_write_en = 1'b0;
  endtask

  // Drain all words; word stall_word sees drain_ready low for 5 OUT cycles.
  task automatic run_drain(input int stall_word);
    drain_start     = 1'b1;
    bus.drain_ready = 1'b1;
    tick();
    drain_start = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      chk($sformatf("drn_rd_%0d", k), 32'({bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, bus.drain_valid}),
          32'({1'b1, 1'b0, 6'(k), 1'b0}));
      tick();
      #1;
      chk($sformatf("drn_resp_%0d", k), 32'({bus.mem_rd_en, bus.drain_valid}), 32'(0));
      if (k == stall_word) bus.drain_ready = 1'b0;
      tick();
      if (k == stall_word) begin
        for (int s = 0; s < 5; s++) begin
          #1;
          chk($sformatf("drn_stall_%0d", s), 32'({bus.mem_rd_en, bus.drain_valid, bus.drain_addr, bus.drain_data}),
              32'({1'b0, 1'b1, 6'(k), exp_data[k]}));
          tick();
        end
        bus.drain_ready = 1'b1;
      end
      #1;
      chk($sformatf("drn_out_%0d", k), 32'({bus.drain_valid, bus.drain_addr, bus.drain_data}),
          32'({1'b1, 6'(k), exp_data[k]}));
      tick();
    end
    #1;
    chk("drn_done", 32'({done, busy, bus.drain_valid}), 32'({1'b1, 1'b0, 1'b0}));
    tick();
    #1;
    chk("drn_done_pulse", 32'(done), 32'(0));
  endtask

  initial begin
    int c;
    int bad;
    logic [5:0] ea;
    bus.wb_write_en = 1'b1;
    bus.wb_addr     = 6'd3;
    bus.wb_data     = 16'hBEEF;
    bus.drain_ready = 1'b1;

    // Reset state: registered outputs zero, writeback still passes through.
    #3;
    chk("rst_regs", 32'({busy, done, bus.drain_valid, bus.drain_addr, bus.drain_data}), 32'(0));
    chk("rst_wb_pass", 32'({bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, bus.mem_wdata}),
        32'({1'b1, 1'b0, 6'd3, 16'hBEEF}));
    bus.wb_write_en = 1'b0;
    #1;
    chk("rst_port_idle", 32'({bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, bus.mem_wdata}), 32'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();

    // Fill with a nonzero pattern so the clear is observable in the model.
    for (int k = 0; k < DEPTH; k++) wb_write(6'(k), 16'(16'h5A00 + k));

    // Clear, no traffic.
    clear_start = 1'b1;
    #1;
    chk("clr_busy_pre", 32'(busy), 32'(0));
    tick();
    clear_start = 1'b0;
    for (c = 1; c <= 64; c++) begin
      #1;
      chk($sformatf("clr_port_%0d", c), 32'({bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, bus.mem_wdata}),
          32'({1'b1, 1'b0, 6'(c - 1), 16'h0}));
      chk($sformatf("clr_status_%0d", c), 32'({busy, done}), 32'({1'b1, 1'b0}));
      tick();
    end
    #1;
    chk("clr_done", 32'({done, busy, bus.mem_wr_en}), 32'({1'b1, 1'b0, 1'b0}));
    tick();
    #1;
    chk("clr_done_pulse", 32'(done), 32'(0));
    bad = 0;
    for (int k = 0; k < DEPTH; k++) if (mem[k] !== 16'h0) bad++;
    chk("clr_mem_zero", 32'(bad), 32'(0));

    // Clear with a writeback collision in cycle 10.
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (c = 1; c <= 66; c++) begin
      bus.wb_write_en = (c == 10);
      bus.wb_addr     = 6'd5;
      bus.wb_data     = 16'h1234;
      #1;
      if (c == 10) begin
        chk("col_wb", 32'({bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, bus.mem_wdata}),
            32'({1'b1, 1'b0, 6'd5, 16'h1234}));
      end else if (c <= 65) begin
        ea = (c < 10) ? 6'(c - 1) : 6'(c - 2);
        chk($sformatf("col_port_%0d", c), 32'({bus.mem_wr_en, bus.mem_addr, bus.mem_wdata}),
            32'({1'b1, ea, 16'h0}));
      end
      chk($sformatf("col_done_%0d", c), 32'(done), 32'(c == 66));
      tick();
    end
    bus.wb_write_en = 1'b0;
    chk("col_mem5", 32'(mem[5]), 32'(16'h1234));
    chk("col_mem9", 32'(mem[9]), 32'(16'h0));

    // Full-rate drain of k+1 at entry k.
    for (int k = 0; k < DEPTH; k++) begin
      wb_write(6'(k), 16'(k + 1));
      exp_data[k] = 16'(k + 1);
    end
    run_drain(-1);

    // Backpressure on word 3.
    run_drain(3);

    // Sign handling of drain words.
    wb_write(6'd0, 16'hFFF0);
    wb_write(6'd1, 16'h0010);
`ifdef ACT_RELU_EN
    exp_data[0] = 16'h0000;
`else
    exp_data[0] = 16'hFFF0;
`endif
    exp_data[1] = 16'h0010;
    run_drain(-1);
    chk("relu_mem_kept", 32'(mem[0]), 32'(16'hFFF0));

    // Simultaneous starts: clear wins; drain_start during CLEAR is ignored.
    clear_start = 1'b1;
    drain_start = 1'b1;
    tick();
    clear_start = 1'b0;
    drain_start = 1'b0;
    for (c = 1; c <= 64; c++) begin
      drain_start = (c == 2);
      #1;
      chk($sformatf("arb_port_%0d", c), 32'({bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, bus.mem_wdata}),
          32'({1'b1, 1'b0, 6'(c - 1), 16'h0}));
      tick();
    end
    drain_start = 1'b0;
    #1;
    chk("arb_done", 32'({done, busy}), 32'({1'b1, 1'b0}));
    for (c = 0; c < 5; c++) begin
      tick();
      #1;
      chk($sformatf("arb_idle_%0d", c), 32'({busy, done, bus.mem_rd_en}), 32'(0));
    end

    // Reset mid-drain while a word is being held.
    wb_write(6'd0, 16'h0777);
    drain_start     = 1'b1;
    bus.drain_ready = 1'b0;
    tick();
    drain_start = 1'b0;
    tick();
    tick();
    #1;
    chk("mid_hold", 32'({bus.drain_valid, bus.drain_data, busy}), 32'({1'b1, 16'h0777, 1'b1}));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_regs", 32'({busy, done, bus.drain_valid, bus.drain_addr, bus.drain_data}), 32'(0));
    chk("mid_rst_port", 32'({bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, bus.mem_wdata}), 32'(0));
    bus.drain_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    for (c = 0; c < 4; c++) begin
      tick();
      #1;
      chk($sformatf("mid_after_%0d", c), 32'({busy, done, bus.drain_valid, bus.mem_rd_en}), 32'(0));
    end
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    #1;
    chk("mid_restart", 32'({bus.mem_rd_en, bus.mem_addr, busy}), 32'({1'b1, 6'd0, 1'b1}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
